scene_radiance_recovery: RTL and testbench
==========================================

Name: scene_radiance_recovery

Overview:
- Consumer end of the transmission-reciprocal path. Takes hazy RGB pixels, the per-pixel reciprocal transmission 1/t (Q2.6) produced by the reciprocal LUT, and the atmospheric light A.
- Computes dehazed radiance per channel: J = A + (I - A) * (1/t).
- Three-stage pipeline with valid/ready backpressure and frame-position tracking. Sits between the reciprocal LUT stage and the output pixel writer.

Parameters:
- IMG_W, 512, pixels per line.
- IMG_H, 512, lines per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept the input pixel.
- in_r, in_g, in_b  in  8 each  hazy pixel channels, unsigned.
- in_recip  in  8  1/t, unsigned Q2.6; legal range 0x40..0xFF; all codes are processed.
- a_r, a_g, a_b  in  8 each  atmospheric light, unsigned; sampled at frame start only.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_r, out_g, out_b  out  8 each  recovered pixel channels.
- out_last  out  1  marks the last pixel of a frame; qualified by out_valid.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream.

Behaviour:
Reset:
- Asynchronous on rst=1. out_valid=0, out_r/g/b=0, out_last=0, frame_done=0.
- All stage valid bits, the pixel counter and the latched A registers clear to 0.
- in_ready is combinational and reads 1 while the pipeline is empty.
- Reset asserted mid-frame discards all in-flight pixels. The next accepted pixel is pixel 0 of a new frame.

Handshake:
- stall = out_valid & ~out_ready.
- in_ready = ~stall.
- A pixel is accepted when in_valid & in_ready.
- On stall, every pipeline register holds, including out_* and their valid bits.
- Without stall, all stages advance every cycle. Bubbles (valid=0) propagate like pixels.
- Latency: 3 cycles from acceptance to out_valid when no stall occurs. Sustained throughput is 1 pixel/cycle.

Frame tracking:
- Pixel counter has width $clog2(IMG_W*IMG_H) and increments on each acceptance.
- Wraps from IMG_W*IMG_H-1 to 0.
- When the counter is 0 at acceptance, a_r/a_g/a_b are latched. Stage 1 uses the live a_* for that pixel and the latched copy for every other pixel of the frame.
- A last flag (counter == IMG_W*IMG_H-1 at acceptance) travels with the pixel and appears as out_last.
- frame_done = registered pulse, asserted the cycle after out_valid & out_ready & out_last.

Datapath, per channel, with A carried alongside each pixel:
- S1: d = {1'b0,I} - {1'b0,A}, 9-bit signed. Register d, A, recip, last.
- S2: p = d * {1'b0,recip}, 18-bit signed (Q.6). Register p, A, last.
- S3: s = ({A,6'b0} + p + 32), 19-bit signed, then arithmetic shift right by 6.
  - Clamp: s < 0 gives 0; s > 255 gives 255; otherwise s[7:0].
  - Register into out_*.
- Rounding is floor(x + 0.5) in Q.6 units.
- Identity: recip = 0x40 gives out = in for all I and A.

Simultaneous events:
- out_ready dropping in the same cycle a new pixel is presented: that pixel is not accepted (in_ready=0). It must be held by the source.
- frame_done and the next frame's first out_valid may coincide.

Test Plan:
1. Identity/latency: after reset, one pixel I=(77,77,77), A=200, recip=0x40, out_ready=1 -> out_valid high exactly 3 cycles after acceptance, out=(77,77,77); in_ready stays 1.
2. Arithmetic: I=200, A=220, recip=0x80 -> 180. I=150, A=100, recip=0x55 -> 166. Check all three channels independently with distinct values.
3. Saturation: I=10, A=230, recip=0xB8 -> 0. I=255, A=100, recip=0xB8 -> 255. recip=0xFF, I=0, A=255 -> 0.
4. Backpressure: stream 20 pixels with out_ready toggling randomly and held low for 5 cycles -> no loss, no duplication; order preserved; out_* stable while stalled; in_ready = 0 exactly during stall.
5. Frame boundary: IMG_W=4, IMG_H=2. Stream 16 pixels with a_* changed mid-frame -> mid-frame change ignored; new A takes effect at pixel 8. out_last on pixels 7 and 15; frame_done pulses one cycle after each, including when acceptance is delayed by a stall.
6. Reset mid-operation: assert rst with 3 pixels in flight and counter=5 -> out_valid=0 and out_*=0 immediately; the next frame's pixel 0 latches new A; out_last occurs after IMG_W*IMG_H fresh pixels.

Source files
------------

// File: rtl/scene_radiance_recovery.sv
// rtl/scene_radiance_recovery.sv - dehaze radiance recovery J = A + (I - A) * (1/t), 3-stage pipeline
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input pixel handshake (in_ready combinational)
//   in_r/in_g/in_b           hazy pixel channels, unsigned 8-bit
//   in_recip                 reciprocal transmission 1/t, unsigned Q2.6
//   a_r/a_g/a_b              atmospheric light, sampled on the first pixel of each frame
//   out_valid/out_ready      output pixel handshake
//   out_r/out_g/out_b        recovered pixel channels, clamped to 0..255
//   out_last                 last pixel of the frame, qualified by out_valid
//   frame_done               one-cycle pulse after the last pixel is taken downstream

module scene_radiance_recovery #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic [7:0] in_recip,
    input  logic [7:0] a_r,
    input  logic [7:0] a_g,
    input  logic [7:0] a_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_last,
    output logic       frame_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX);
    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

    logic          stall;
    logic          accept;
    logic          first;
    logic [CW-1:0] cnt;

    logic [7:0] pix    [3];
    logic [7:0] a_live [3];
    logic [7:0] a_lat  [3];
    logic [7:0] a_use  [3];

    // Stage 1
    logic              v1;
    logic              last1;
    logic [7:0]        recip1;
    logic signed [8:0] d1 [3];
    logic [7:0]        a1 [3];

    // Stage 2
    logic               v2;
    logic               last2;
    logic signed [17:0] p2 [3];
    logic [7:0]         a2 [3];

    // Stage 3 combinational result
    logic signed [12:0] q  [3];
    logic [7:0]         cl [3];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign first    = (cnt == '0);

    // The first pixel of a frame must use the live A because the latch only
    // captures it on that same edge.
    always_comb begin
        pix[0]    = in_r;
        pix[1]    = in_g;
        pix[2]    = in_b;
        a_live[0] = a_r;
        a_live[1] = a_g;
        a_live[2] = a_b;
        for (int c = 0; c < 3; c++) begin
            a_use[c] = first ? a_live[c] : a_lat[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int c = 0; c < 3; c++) begin
                a_lat[c] <= '0;
            end
        end else if (accept) begin
            if (first) begin
                for (int c = 0; c < 3; c++) begin
                    a_lat[c] <= a_live[c];
                end
            end
            cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            last1  <= 1'b0;
            recip1 <= '0;
            for (int c = 0; c < 3; c++) begin
                d1[c] <= '0;
                a1[c] <= '0;
            end
        end else if (!stall) begin
            v1     <= accept;
            last1  <= accept & (cnt == LAST_IDX);
            recip1 <= in_recip;
            for (int c = 0; c < 3; c++) begin
                d1[c] <= $signed({1'b0, pix[c]}) - $signed({1'b0, a_use[c]});
                a1[c] <= a_use[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                p2[c] <= '0;
                a2[c] <= '0;
            end
        end else if (!stall) begin
            v2    <= v1;
            last2 <= last1;
            for (int c = 0; c < 3; c++) begin
                // |d| <= 255 and recip <= 255, so the product fits 18 bits signed.
                p2[c] <= 18'(d1[c]) * 18'($signed({1'b0, recip1}));
                a2[c] <= a1[c];
            end
        end
    end

    // A*64 + p + 0.5 LSB in Q.6, then drop the fraction and saturate.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            q[c] = 13'(($signed({5'b0, a2[c], 6'b0}) + 19'(p2[c]) + 19'sd32) >>> 6);
            if (q[c][12]) begin
                cl[c] = 8'd0;
            end else if (|q[c][11:8]) begin
                cl[c] = 8'd255;
            end else begin
                cl[c] = q[c][7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_r      <= '0;
            out_g      <= '0;
            out_b      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & out_last;
            if (!stall) begin
                out_valid <= v2;
                out_last  <= last2;
                out_r     <= cl[0];
                out_g     <= cl[1];
                out_b     <= cl[2];
            end
        end
    end

endmodule

// File: tb/tb_scene_radiance_recovery.sv
// tb/tb_scene_radiance_recovery.sv - directed self-checking bench for scene_radiance_recovery

module tb_scene_radiance_recovery;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0, in_recip = 8'h40;
    logic [7:0] a_r = '0, a_g = '0, a_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_r, out_g, out_b;
    logic       out_last;
    logic       frame_done;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    scene_radiance_recovery #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .in_recip   (in_recip),
        .a_r        (a_r),
        .a_g        (a_g),
        .a_b        (a_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    // Reference: J = A + (I - A) * recip / 64, rounded half-up, clamped.
    function automatic logic [7:0] model(input int i, input int a, input int rc);
        int v;
        v = a * 64 + (i - a) * rc + 32;
        if (v < 0) return 8'd0;
        v = v / 64;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset, push one pixel (as pixel 0, so live A applies), wait for it to emerge.
    task automatic send_pixel(input logic [7:0] ir, ig, ib, ar, ag, ab, rc,
                              output logic [7:0] orr, og, ob,
                              output int lat, output bit rdy_ok);
        do_reset();
        @(negedge clk);
        in_r = ir; in_g = ig; in_b = ib;
        a_r = ar; a_g = ag; a_b = ab;
        in_recip = rc;
        in_valid = 1'b1;
        #1;
        rdy_ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        rdy_ok &= in_ready;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            rdy_ok &= in_ready;
        end
        orr = out_r; og = out_g; ob = out_b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0 ||
            out_r !== 8'd0 || out_g !== 8'd0 || out_b !== 8'd0) begin
            errs++;
            $display("FAIL reset_outputs: got v=%b l=%b fd=%b rgb=%0d,%0d,%0d want all zero",
                     out_valid, out_last, frame_done, out_r, out_g, out_b);
        end
        vec++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_identity();
        logic [7:0] r, g, b;
        int lat;
        bit rdy;
        send_pixel(8'd77, 8'd77, 8'd77, 8'd200, 8'd200, 8'd200, 8'h40, r, g, b, lat, rdy);
        vec++;
        if (lat !== 3) begin
            errs++;
            $display("FAIL identity_latency: got %0d want 3", lat);
        end
        vec++;
        if (r !== 8'd77 || g !== 8'd77 || b !== 8'd77) begin
            errs++;
            $display("FAIL identity_77: got %0d,%0d,%0d want 77,77,77", r, g, b);
        end
        vec++;
        if (rdy !== 1'b1) begin
            errs++;
            $display("FAIL identity_in_ready: got %b want 1 throughout", rdy);
        end
        send_pixel(8'd0, 8'd128, 8'd255, 8'd255, 8'd3, 8'd0, 8'h40, r, g, b, lat, rdy);
        vec++;
        if (r !== 8'd0 || g !== 8'd128 || b !== 8'd255) begin
            errs++;
            $display("FAIL identity_extremes: got %0d,%0d,%0d want 0,128,255", r, g, b);
        end
    endtask

    task automatic test_arith();
        logic [7:0] r, g, b;
        int lat;
        bit rdy;
        send_pixel(8'd200, 8'd100, 8'd30, 8'd220, 8'd50, 8'd20, 8'h80, r, g, b, lat, rdy);
        vec++;
        if (r !== 8'd180 || g !== 8'd150 || b !== 8'd40) begin
            errs++;
            $display("FAIL arith_recip80: got %0d,%0d,%0d want 180,150,40", r, g, b);
        end
        send_pixel(8'd150, 8'd60, 8'd40, 8'd100, 8'd90, 8'd0, 8'h55, r, g, b, lat, rdy);
        vec++;
        if (r !== 8'd166 || g !== 8'd50 || b !== 8'd53) begin
            errs++;
            $display("FAIL arith_recip55: got %0d,%0d,%0d want 166,50,53", r, g, b);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] r, g, b;
        int lat;
        bit rdy;
        send_pixel(8'd10, 8'd255, 8'd128, 8'd230, 8'd100, 8'd128, 8'hB8, r, g, b, lat, rdy);
        vec++;
        if (r !== 8'd0 || g !== 8'd255 || b !== 8'd128) begin
            errs++;
            $display("FAIL sat_recipB8: got %0d,%0d,%0d want 0,255,128", r, g, b);
        end
        send_pixel(8'd0, 8'd255, 8'd100, 8'd255, 8'd0, 8'd100, 8'hFF, r, g, b, lat, rdy);
        vec++;
        if (r !== 8'd0 || g !== 8'd255 || b !== 8'd100) begin
            errs++;
            $display("FAIL sat_recipFF: got %0d,%0d,%0d want 0,255,100", r, g, b);
        end
    endtask

    // mode 0: random out_ready with a forced 5-cycle stall, 20 pixels
    // mode 1: 16 pixels, A changed from pixel 3, stall over the first out_last
    // mode 2: 8 pixels straight through (after a mid-frame reset)
    task automatic test_stream(input string name, input int mode, input bit pre_reset);
        logic [24:0] exp_q[$];
        logic [24:0] e;
        logic [7:0]  la [3];
        logic [7:0]  ca [3];
        logic [7:0]  hr, hg, hb;
        logic        hl, prev_stall, prev_done;
        int n, idx, got, mcnt, fd_cnt, fd_want, pi, pg, pb, pc;
        n = (mode == 0) ? 20 : (mode == 1) ? 16 : 8;
        fd_want = (mode == 0) ? 2 : (mode == 1) ? 2 : 1;
        idx = 0; got = 0; mcnt = 0; fd_cnt = 0;
        prev_stall = 1'b0; prev_done = 1'b0;
        hr = '0; hg = '0; hb = '0; hl = 1'b0;
        for (int c = 0; c < 3; c++) la[c] = '0;
        if (pre_reset) do_reset();
        for (int cyc = 0; cyc < 400 && (got < n || prev_done); cyc++) begin
            @(negedge clk);
            case (mode)
                0: out_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : ($urandom_range(0, 3) != 0);
                1: out_ready = !(cyc == 10 || cyc == 11);
                default: out_ready = 1'b1;
            endcase
            ca[0] = (mode == 1 && idx >= 3) ? 8'd40  : (mode == 2) ? 8'd90  : 8'd180;
            ca[1] = (mode == 1 && idx >= 3) ? 8'd210 : (mode == 2) ? 8'd10  : 8'd60;
            ca[2] = (mode == 1 && idx >= 3) ? 8'd120 : (mode == 2) ? 8'd240 : 8'd130;
            a_r = ca[0]; a_g = ca[1]; a_b = ca[2];
            pi = (idx * 53 + 17 + mode * 7) % 256;
            pg = (idx * 101 + 200) % 256;
            pb = (idx * 29 + 90 + mode * 3) % 256;
            pc = 64 + (idx * 37) % 192;
            in_valid = (idx < n);
            in_r = 8'(pi); in_g = 8'(pg); in_b = 8'(pb); in_recip = 8'(pc);
            #1;
            vec++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errs++;
                $display("FAIL %s_in_ready cyc%0d: got %b want %b", name, cyc, in_ready,
                         !(out_valid && !out_ready));
            end
            vec++;
            if (frame_done !== prev_done) begin
                errs++;
                $display("FAIL %s_frame_done cyc%0d: got %b want %b", name, cyc, frame_done, prev_done);
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (prev_stall) begin
                vec++;
                if (out_valid !== 1'b1 || {out_r, out_g, out_b, out_last} !== {hr, hg, hb, hl}) begin
                    errs++;
                    $display("FAIL %s_hold cyc%0d: got v=%b %0d,%0d,%0d l=%b want held %0d,%0d,%0d l=%b",
                             name, cyc, out_valid, out_r, out_g, out_b, out_last, hr, hg, hb, hl);
                end
            end
            prev_done = 1'b0;
            if (out_valid && out_ready) begin
                vec++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL %s_extra cyc%0d: got unexpected pixel %0d,%0d,%0d want none",
                             name, cyc, out_r, out_g, out_b);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_r, out_g, out_b} !== e) begin
                        errs++;
                        $display("FAIL %s_pix%0d: got l=%b %0d,%0d,%0d want l=%b %0d,%0d,%0d",
                                 name, got, out_last, out_r, out_g, out_b,
                                 e[24], e[23:16], e[15:8], e[7:0]);
                    end
                end
                got++;
                prev_done = out_last;
            end
            prev_stall = out_valid && !out_ready;
            hr = out_r; hg = out_g; hb = out_b; hl = out_last;
            if (in_valid && in_ready) begin
                if (mcnt == 0) for (int c = 0; c < 3; c++) la[c] = ca[c];
                exp_q.push_back({(mcnt == N - 1), model(pi, la[0], pc),
                                 model(pg, la[1], pc), model(pb, la[2], pc)});
                mcnt = (mcnt + 1) % N;
                idx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vec++;
        if (got !== n || exp_q.size() !== 0) begin
            errs++;
            $display("FAIL %s_count: got %0d pixels (%0d pending) want %0d", name, got, exp_q.size(), n);
        end
        vec++;
        if (fd_cnt !== fd_want) begin
            errs++;
            $display("FAIL %s_frame_done_count: got %0d want %0d", name, fd_cnt, fd_want);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_r = 8'd11; a_g = 8'd22; a_b = 8'd33;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_r = 8'(k * 40 + 20); in_g = 8'(k * 7); in_b = 8'(250 - k);
            in_recip = 8'h70;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vec++;
        if (out_valid !== 1'b1) begin
            errs++;
            $display("FAIL midreset_pre_valid: got %b want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        vec++;
        if (out_valid !== 1'b0 || out_r !== 8'd0 || out_g !== 8'd0 || out_b !== 8'd0 ||
            out_last !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL midreset_clear: got v=%b %0d,%0d,%0d l=%b rdy=%b want 0,0,0,0,0 rdy=1",
                     out_valid, out_r, out_g, out_b, out_last, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        test_stream("midreset", 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_arith();
        test_saturation();
        test_stream("backpressure", 0, 1'b1);
        test_stream("frame", 1, 1'b1);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
